// File: rtl/axi_wresp_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : axi_wresp_monitor
//  Description : Passive AXI4 write-response monitor with sticky error flags.
//                Define AXI_WRESP_MON_ID_CHECK_EN for per-ID BID tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_wresp_monitor #(
    parameter int C_AXI_ID_WIDTH  = 4,
    parameter int MAX_WAIT        = 5,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                     AXI_ACLK,
    input  logic                                     AXI_ARESETN,
    input  logic                                     AXI_AWVALID,
    input  logic                                     AXI_AWREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]                AXI_AWID,
    input  logic                                     AXI_BVALID,
    input  logic                                     AXI_BREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]                AXI_BID,
    input  logic [1:0]                               AXI_BRESP,
    input  logic                                     err_clear,
    output logic [6:0]                               err_flags,
    output logic                                     err_any,
    output logic [2:0]                               first_err_code,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding
);

    localparam int OUTST_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int WAIT_W  = $clog2(MAX_WAIT + 2);

    localparam logic [OUTST_W-1:0] C_MAX_OUT  = OUTST_W'(MAX_OUTSTANDING);
    localparam logic [WAIT_W-1:0]  C_MAX_WAIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0]  C_WAIT_SAT = WAIT_W'(MAX_WAIT + 1);

    logic                      w_aw_hs;
    logic                      w_b_hs;
    logic                      w_stall;
    logic                      w_bid_unknown;
    logic [6:0]                w_new_err;
    logic [2:0]                w_first_code;

    logic                      r_rst_seen;
    logic                      r_prev_stall;
    logic [C_AXI_ID_WIDTH-1:0] r_prev_bid;
    logic [1:0]                r_prev_bresp;
    logic [WAIT_W-1:0]         r_stall_cnt;
    logic [OUTST_W-1:0]        r_outst;
    logic [6:0]                r_flags;
    logic [2:0]                r_code;

    assign w_aw_hs = AXI_AWVALID & AXI_AWREADY;
    assign w_b_hs  = AXI_BVALID & AXI_BREADY;
    assign w_stall = AXI_BVALID & ~AXI_BREADY;

`ifdef AXI_WRESP_MON_ID_CHECK_EN
    localparam int C_NUM_IDS = 2 ** C_AXI_ID_WIDTH;

    logic [C_NUM_IDS-1:0] w_id_zero;

    generate
        for (genvar gi = 0; gi < C_NUM_IDS; gi++) begin : g_id_cnt
            logic               w_inc;
            logic               w_dec;
            logic [OUTST_W-1:0] r_cnt;

            assign w_inc         = w_aw_hs & (AXI_AWID == C_AXI_ID_WIDTH'(gi));
            assign w_dec         = w_b_hs  & (AXI_BID  == C_AXI_ID_WIDTH'(gi));
            assign w_id_zero[gi] = (r_cnt == '0);

            always_ff @(posedge AXI_ACLK) begin
                if (!AXI_ARESETN) begin
                    r_cnt <= '0;
                end else if (w_inc && !w_dec && r_cnt != C_MAX_OUT) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_dec && !w_inc && r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    endgenerate

    assign w_bid_unknown = w_b_hs & w_id_zero[AXI_BID];
`else
    logic w_unused_awid;
    assign w_unused_awid = ^AXI_AWID;
    assign w_bid_unknown = 1'b0;
`endif

    always_comb begin
        w_new_err    = '0;
        w_new_err[0] = r_rst_seen & AXI_BVALID;
        w_new_err[1] = r_prev_stall & ~AXI_BVALID;
        w_new_err[2] = r_prev_stall & ((AXI_BID != r_prev_bid) | (AXI_BRESP != r_prev_bresp));
        w_new_err[3] = w_stall & (r_stall_cnt == C_MAX_WAIT);
        // A same-cycle AW does not excuse an early B: the AW must already be counted.
        w_new_err[4] = w_b_hs & (r_outst == '0);
        w_new_err[5] = w_aw_hs & ~w_b_hs & (r_outst == C_MAX_OUT);
        w_new_err[6] = w_bid_unknown;
    end

    always_comb begin
        w_first_code = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (w_new_err[i]) begin
                w_first_code = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            r_rst_seen   <= 1'b1;
            r_prev_stall <= 1'b0;
            r_prev_bid   <= '0;
            r_prev_bresp <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_rst_seen   <= 1'b0;
            r_prev_stall <= w_stall;
            r_prev_bid   <= AXI_BID;
            r_prev_bresp <= AXI_BRESP;
            if (!w_stall) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != C_WAIT_SAT) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            r_outst <= '0;
        end else begin
            case ({w_aw_hs, w_b_hs})
                2'b10:   if (r_outst != C_MAX_OUT) r_outst <= r_outst + 1'b1;
                2'b01:   if (r_outst != '0)        r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // A clear coinciding with a new error keeps the new error, not a blank slate.
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            r_flags <= '0;
            r_code  <= '0;
        end else begin
            r_flags <= (err_clear ? 7'd0 : r_flags) | w_new_err;
            if ((|w_new_err) && (err_clear || r_flags == '0)) begin
                r_code <= w_first_code;
            end else if (err_clear) begin
                r_code <= '0;
            end
        end
    end

    assign err_flags      = r_flags;
    assign err_any        = |r_flags;
    assign first_err_code = r_code;
    assign outstanding    = r_outst;

endmodule
`default_nettype wire

// File: tb/tb_axi_wresp_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_wresp_monitor
//  Description : Directed and randomized bench for axi_wresp_monitor against
//                a cycle-level reference model of the monitor's rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_wresp_monitor;

    localparam int IDW      = 4;
    localparam int MAX_WAIT = 5;
    localparam int MAX_OUT  = 16;
    localparam int OW       = $clog2(MAX_OUT + 1);

    logic           AXI_ACLK = 1'b0;
    logic           AXI_ARESETN;
    logic           AXI_AWVALID;
    logic           AXI_AWREADY;
    logic [IDW-1:0] AXI_AWID;
    logic           AXI_BVALID;
    logic           AXI_BREADY;
    logic [IDW-1:0] AXI_BID;
    logic [1:0]     AXI_BRESP;
    logic           err_clear;
    logic [6:0]     err_flags;
    logic           err_any;
    logic [2:0]     first_err_code;
    logic [OW-1:0]  outstanding;

    axi_wresp_monitor #(
        .C_AXI_ID_WIDTH  (IDW),
        .MAX_WAIT        (MAX_WAIT),
        .MAX_OUTSTANDING (MAX_OUT)
    ) u_dut (
        .AXI_ACLK       (AXI_ACLK),
        .AXI_ARESETN    (AXI_ARESETN),
        .AXI_AWVALID    (AXI_AWVALID),
        .AXI_AWREADY    (AXI_AWREADY),
        .AXI_AWID       (AXI_AWID),
        .AXI_BVALID     (AXI_BVALID),
        .AXI_BREADY     (AXI_BREADY),
        .AXI_BID        (AXI_BID),
        .AXI_BRESP      (AXI_BRESP),
        .err_clear      (err_clear),
        .err_flags      (err_flags),
        .err_any        (err_any),
        .first_err_code (first_err_code),
        .outstanding    (outstanding)
    );

    always #5 AXI_ACLK = ~AXI_ACLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state, kept as plain integers
    int       m_flags;
    int       m_code;
    int       m_outst;
    int       m_stall_run;
    bit       m_prev_stall;
    int       m_prev_bid;
    int       m_prev_bresp;
    bit       m_rst_seen;
    int       m_id_cnt [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        bit aw, b, stall;
        int nw;
        if (!AXI_ARESETN) begin
            m_flags = 0; m_code = 0; m_outst = 0; m_stall_run = 0;
            m_prev_stall = 0; m_prev_bid = 0; m_prev_bresp = 0; m_rst_seen = 1;
            foreach (m_id_cnt[i]) m_id_cnt[i] = 0;
            return;
        end
        aw    = AXI_AWVALID && AXI_AWREADY;
        b     = AXI_BVALID && AXI_BREADY;
        stall = AXI_BVALID && !AXI_BREADY;
        nw = 0;
        if (m_rst_seen && AXI_BVALID)                    nw |= 1;
        if (m_prev_stall && !AXI_BVALID)                 nw |= 2;
        if (m_prev_stall && (int'(AXI_BID) != m_prev_bid || int'(AXI_BRESP) != m_prev_bresp))
                                                         nw |= 4;
        if (stall && m_stall_run == MAX_WAIT)            nw |= 8;
        if (b && m_outst == 0)                           nw |= 16;
        if (aw && !b && m_outst == MAX_OUT)              nw |= 32;
`ifdef AXI_WRESP_MON_ID_CHECK_EN
        if (b && m_id_cnt[AXI_BID] == 0)                 nw |= 64;
`endif
        if (nw != 0 && (err_clear || m_flags == 0)) begin
            for (int i = 0; i < 7; i++) begin
                if (nw[i]) begin
                    m_code = i + 1;
                    break;
                end
            end
        end else if (err_clear) begin
            m_code = 0;
        end
        m_flags = (err_clear ? 0 : m_flags) | nw;
        if (aw && !b) m_outst = (m_outst < MAX_OUT) ? m_outst + 1 : MAX_OUT;
        if (b && !aw) m_outst = (m_outst > 0) ? m_outst - 1 : 0;
        if (!(aw && b && AXI_AWID == AXI_BID)) begin
            if (aw && m_id_cnt[AXI_AWID] < MAX_OUT) m_id_cnt[AXI_AWID]++;
            if (b && m_id_cnt[AXI_BID] > 0)         m_id_cnt[AXI_BID]--;
        end
        m_stall_run  = stall ? ((m_stall_run < 1000) ? m_stall_run + 1 : 1000) : 0;
        m_prev_stall = stall;
        m_prev_bid   = int'(AXI_BID);
        m_prev_bresp = int'(AXI_BRESP);
        m_rst_seen   = 0;
    endtask

    task automatic tick();
        @(posedge AXI_ACLK);
        model_edge();
        #1;
        cyc++;
        chk("err_flags", 32'(err_flags), 32'(m_flags));
        chk("err_any", 32'(err_any), 32'(m_flags != 0));
        chk("first_err_code", 32'(first_err_code), 32'(m_code));
        chk("outstanding", 32'(outstanding), 32'(m_outst));
    endtask

    task automatic idle();
        AXI_AWVALID = 0; AXI_AWREADY = 0; AXI_AWID = '0;
        AXI_BVALID  = 0; AXI_BREADY  = 0; AXI_BID  = '0; AXI_BRESP = '0;
        err_clear   = 0;
    endtask

    task automatic aw(input int id);
        idle(); AXI_AWVALID = 1; AXI_AWREADY = 1; AXI_AWID = IDW'(id);
    endtask

    task automatic bph(input int id, input bit rdy, input int resp);
        idle(); AXI_BVALID = 1; AXI_BREADY = rdy; AXI_BID = IDW'(id); AXI_BRESP = 2'(resp);
    endtask

    task automatic do_reset(input int n);
        idle(); AXI_ARESETN = 0;
        repeat (n) tick();
        AXI_ARESETN = 1;
    endtask

    logic [6:0] exp6;

    initial begin
        idle();
        do_reset(3);
        chk("reset_flags", 32'(err_flags), 32'h0);
        chk("reset_outst", 32'(outstanding), 32'h0);

        // BVALID high on the first cycle out of reset
        bph(0, 0, 0); tick();
        chk("bvalid_after_reset", 32'(err_flags), 32'h01);
        chk("bvalid_after_reset_code", 32'(first_err_code), 32'd1);
        do_reset(2);
        idle(); tick();

        // Five stalls is within the limit
        aw(3); tick();
        chk("outst_one", 32'(outstanding), 32'd1);
        repeat (5) begin bph(3, 0, 0); tick(); end
        bph(3, 1, 0); tick();
        idle(); tick();
        chk("five_stall_flags", 32'(err_flags), 32'h0);
        chk("five_stall_outst", 32'(outstanding), 32'd0);

        // Six stalls trips the BREADY latency check
        aw(1); tick();
        repeat (6) begin bph(1, 0, 1); tick(); end
        chk("six_stall_flags", 32'(err_flags), 32'h08);
        chk("six_stall_code", 32'(first_err_code), 32'd4);
        bph(1, 1, 1); tick();
        idle(); err_clear = 1; tick();
        idle(); tick();
        chk("clear_flags", 32'(err_flags), 32'h0);
        chk("clear_code", 32'(first_err_code), 32'd0);

        // Payload change then BVALID drop while stalled
        aw(0); tick();
        bph(0, 0, 0); tick();
        bph(0, 0, 2); tick();
        idle(); AXI_BRESP = 2'd2; tick();
        chk("stable_flags", 32'(err_flags), 32'h06);
        chk("stable_code", 32'(first_err_code), 32'd3);
        bph(0, 1, 0); tick();
        idle(); err_clear = 1; tick();

        // Overflow then underflow
        for (int i = 0; i < 17; i++) begin aw(i % 4); tick(); end
        chk("ovf_flags", 32'(err_flags), 32'h20);
        chk("ovf_code", 32'(first_err_code), 32'd6);
        chk("ovf_outst", 32'(outstanding), 32'd16);
        for (int i = 0; i < 17; i++) begin bph(i % 4, 1, 0); tick(); end
        idle(); tick();
        chk("unf_flags", 32'(err_flags), 32'h30);
        chk("unf_code", 32'(first_err_code), 32'd6);
        chk("unf_outst", 32'(outstanding), 32'd0);
        err_clear = 1; tick();
        idle(); tick();
        chk("clear2_flags", 32'(err_flags), 32'h0);

        // Unknown BID, then a same-cycle AW/B on different IDs
        aw(2); tick();
        bph(5, 1, 0); tick();
        idle(); tick();
`ifdef AXI_WRESP_MON_ID_CHECK_EN
        exp6 = 7'h40;
        chk("bid_unknown_code", 32'(first_err_code), 32'd7);
`else
        exp6 = 7'h00;
`endif
        chk("bid_unknown_flags", 32'(err_flags), 32'(exp6));
        err_clear = 1; tick();
        aw(2); tick();
        aw(1); AXI_BVALID = 1; AXI_BREADY = 1; AXI_BID = 4'd2; tick();
        chk("same_cycle_outst", 32'(outstanding), 32'd1);
        bph(1, 1, 0); tick();
        idle(); tick();
        chk("same_cycle_flags", 32'(err_flags), 32'h0);

        // Randomized traffic with occasional protocol abuse
        begin
            int  rdy_pct = 80;
            int  aw_pct  = 40;
            bit  drv_stall = 0;
            for (int c = 0; c < 3000; c++) begin
                if (c % 200 == 0) begin
                    case ($urandom_range(0, 2))
                        0: begin rdy_pct = 85; aw_pct = 40; end
                        1: begin rdy_pct = 30; aw_pct = 70; end
                        default: begin rdy_pct = 5; aw_pct = 20; end
                    endcase
                end
                AXI_ARESETN = ($urandom_range(0, 299) != 0);
                AXI_AWVALID = ($urandom_range(0, 99) < aw_pct);
                AXI_AWREADY = ($urandom_range(0, 3) != 0);
                AXI_AWID    = IDW'($urandom_range(0, 3));
                if (!(drv_stall && $urandom_range(0, 9) != 0)) begin
                    AXI_BVALID = 1'($urandom_range(0, 1));
                    AXI_BID    = IDW'($urandom_range(0, 3));
                    AXI_BRESP  = 2'($urandom_range(0, 3));
                end
                AXI_BREADY = ($urandom_range(0, 99) < rdy_pct);
                err_clear  = ($urandom_range(0, 29) == 0);
                drv_stall  = AXI_BVALID && !AXI_BREADY;
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
